// File: rtl/fifo_pkg.sv
// Shared sizing constants and default thresholds for the 16-entry FIFO controller.
package fifo_pkg;
  localparam int unsigned FIFO_DEPTH       = 16;
  localparam int unsigned FIFO_AW          = 4;
  localparam int unsigned FIFO_PW          = 5;
  localparam int unsigned FIFO_AF_LEVEL    = 14;
  localparam int unsigned FIFO_AE_LEVEL    = 2;
endpackage

// File: rtl/addsub5.sv
// 5-bit add/subtract cell: y = a + b (sub=0) or a - b (sub=1), with carry-out and signed overflow.
module addsub5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       sub,
  output logic [4:0] y,
  output logic       cout,
  output logic       ovf
);
  logic [4:0] b_x;
  logic [5:0] sum;

  // Subtraction as a + ~b + 1.
  assign b_x  = b ^ {5{sub}};
  assign sum  = {1'b0, a} + {1'b0, b_x} + {5'b0, sub};
  assign y    = sum[4:0];
  assign cout = sum[5];
  assign ovf  = (a[4] == b_x[4]) && (sum[4] != a[4]);
endmodule

// File: rtl/fifo_ptr_ctrl16.sv
// Pointer/status controller for a 16-entry synchronous FIFO: gated enables,
// storage addresses, occupancy, thresholds and sticky error flags.
module fifo_ptr_ctrl16
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = FIFO_DEPTH,
  parameter int unsigned AW       = FIFO_AW,
  parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL,
  parameter int unsigned AE_LEVEL = FIFO_AE_LEVEL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic [4:0]    count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          wr_ovf,
  output logic          rd_udf
);
  localparam logic [FIFO_PW-1:0] AF_L  = FIFO_PW'(AF_LEVEL);
  localparam logic [FIFO_PW-1:0] AE_L  = FIFO_PW'(AE_LEVEL);
  localparam logic [FIFO_PW-1:0] FULLC = FIFO_PW'(DEPTH);

  logic [FIFO_PW-1:0] wptr_q, wptr_d;
  logic [FIFO_PW-1:0] rptr_q, rptr_d;
  logic               wr_ovf_q, wr_ovf_d;
  logic               rd_udf_q, rd_udf_d;
  logic [FIFO_PW-1:0] count_w;
  logic               unused_cout;
  logic               unused_ovf;

  // Modulo-32 difference is the occupancy; carry and overflow carry no meaning here.
  addsub5 u_count_sub (
    .a    (wptr_q),
    .b    (rptr_q),
    .sub  (1'b1),
    .y    (count_w),
    .cout (unused_cout),
    .ovf  (unused_ovf)
  );

  assign full  = (wptr_q[4] != rptr_q[4]) && (wptr_q[3:0] == rptr_q[3:0]);
  assign empty = (wptr_q == rptr_q);
  assign wr_en = wr_req & ~full & ~rst;
  assign rd_en = rd_req & ~empty & ~rst;

  assign count        = count_w;
  assign waddr        = wptr_q[AW-1:0];
  assign raddr        = rptr_q[AW-1:0];
  assign almost_full  = (count_w >= AF_L);
  assign almost_empty = (count_w <= AE_L);
  assign wr_ovf       = wr_ovf_q;
  assign rd_udf       = rd_udf_q;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    wr_ovf_d = wr_ovf_q | (wr_req & full);
    rd_udf_d = rd_udf_q | (rd_req & empty);
    if (wr_en) wptr_d = wptr_q + 5'd1;
    if (rd_en) rptr_d = rptr_q + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      wr_ovf_q <= 1'b0;
      rd_udf_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wr_ovf_q <= wr_ovf_d;
      rd_udf_q <= rd_udf_d;
    end
  end

  // Full/empty decoded from pointer bits must always agree with the arithmetic count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (full == (count_w == FULLC));
      assert (empty == (count_w == 5'd0));
    end
  end
endmodule
